// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the IF/ID payload type.
// Build option: FETCH_IRQ_EN adds the interrupt flag to the IF/ID payload.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] IRQ_VECTOR       = 32'h8000_0004;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  // IF/ID payload; valid is kept beside it in the pipe register.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
`ifdef FETCH_IRQ_EN
    logic        irq;
`endif
  } ifid_t;

  // Redirect targets always land on a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_pipe_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
// Build option: FETCH_IRQ_EN widens the payload through cpu_pkg::ifid_t.
module fetch_pipe_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  input  logic  hold,
  input  logic  load,
  input  ifid_t d,
  output ifid_t q,
  output logic  valid
);

  // Register the fetched word; a flush leaves a NOP bubble behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      q       <= '0;
      q.instr <= NOP_INSTR;
      valid   <= 1'b0;
    end else if (hold) begin
      q     <= q;
      valid <= valid;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection, IF/ID register.
// Build option: FETCH_IRQ_EN adds irq / if_id_irq and the interrupt vector path.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
`ifdef FETCH_IRQ_EN
  input  logic        irq,
  output logic        if_id_irq,
`endif
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  logic [31:0] pc, pc_nxt, pc_plus4;
  logic        jump_go, irq_go, flush, hold;
  ifid_t       ifid_d, ifid_q;

  assign pc_plus4 = pc + 32'd4;            // wraps modulo 2^32
  assign jump_go  = jump_en & ~stall;      // a stalled jump is re-presented by ID
  assign flush    = branch_taken | jump_go;
  assign hold     = stall & ~branch_taken;

`ifdef FETCH_IRQ_EN
  // Interrupts are taken only from user space and only on an otherwise sequential cycle.
  assign irq_go = irq & ~pc[31] & ~stall & ~branch_taken & ~jump_en;
`else
  assign irq_go = 1'b0;
`endif

  // Next-PC priority: branch, unstalled jump, interrupt, stall, sequential.
  always_comb begin
    pc_nxt = pc_plus4;
    if (branch_taken)  pc_nxt = word_align(branch_target);
    else if (jump_go)  pc_nxt = word_align(jump_target);
    else if (irq_go)   pc_nxt = IRQ_VECTOR;
    else if (stall)    pc_nxt = pc;
  end

  // IF/ID payload: the fetched word, or a NOP carrying the interrupted PC for EPC.
  always_comb begin
    ifid_d          = '0;
    ifid_d.instr    = imem_instr;
    ifid_d.pc_plus4 = pc_plus4;
`ifdef FETCH_IRQ_EN
    if (irq_go) begin
      ifid_d.instr    = NOP_INSTR;
      ifid_d.pc_plus4 = pc;
      ifid_d.irq      = 1'b1;
    end
`endif
  end

  // Program counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_nxt;
  end

  fetch_pipe_reg u_ifid (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .hold  (hold),
    .load  (1'b1),
    .d     (ifid_d),
    .q     (ifid_q),
    .valid (if_id_valid)
  );

  assign imem_addr      = pc;
  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc_plus4 = ifid_q.pc_plus4;
`ifdef FETCH_IRQ_EN
  assign if_id_irq      = ifid_q.irq;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; FETCH_IRQ_EN enables the interrupt vectors.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump_en;
  logic [31:0] branch_target, jump_target, imem_addr, imem_instr;
  logic [31:0] if_id_instr, if_id_pc_plus4;
  logic        if_id_valid;
`ifdef FETCH_IRQ_EN
  logic        irq, if_id_irq;
`endif

  int n_chk = 0;
  int n_pass = 0;

  // Instruction memory model: word content is the address with a fixed tag.
  assign imem_instr = imem_addr ^ 32'hA5A5_0000;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
`ifdef FETCH_IRQ_EN
    .irq            (irq),
    .if_id_irq      (if_id_irq),
`endif
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
    branch_target = '0; jump_target = '0;
`ifdef FETCH_IRQ_EN
    irq = 1'b0;
`endif
    tick();
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4",   if_id_pc_plus4, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
`ifdef FETCH_IRQ_EN
    chk("rst_irq",   {31'b0, if_id_irq}, 32'h0);
`endif
    reset = 1'b0;
    chk("run_addr0", imem_addr, 32'h0);
    tick();
    chk("run_addr4",  imem_addr, 32'h4);
    chk("run_pc4_4",  if_id_pc_plus4, 32'h4);
    chk("run_valid",  {31'b0, if_id_valid}, 32'h1);
    chk("run_instr0", if_id_instr, 32'hA5A5_0000);
    tick();
    chk("run_addr8", imem_addr, 32'h8);
    chk("run_pc4_8", if_id_pc_plus4, 32'h8);
    tick();
    chk("run_addrC", imem_addr, 32'hC);
    chk("run_pc4_C", if_id_pc_plus4, 32'hC);
    tick();
    chk("run_addr10", imem_addr, 32'h10);

    // Stall three cycles at 0x10.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr",  imem_addr, 32'h10);
      chk("stall_pc4",   if_id_pc_plus4, 32'h10);
      chk("stall_instr", if_id_instr, 32'hA5A5_000C);
      chk("stall_valid", {31'b0, if_id_valid}, 32'h1);
    end
    stall = 1'b0;
    tick();
    chk("resume_addr",  imem_addr, 32'h14);
    chk("resume_pc4",   if_id_pc_plus4, 32'h14);
    chk("resume_instr", if_id_instr, 32'hA5A5_0010);
    tick(); tick(); tick();
    chk("pre_br_addr", imem_addr, 32'h20);

    // Branch with misaligned target.
    branch_taken = 1'b1; branch_target = 32'h2B;
    tick();
    branch_taken = 1'b0;
    chk("br_addr",  imem_addr, 32'h28);
    chk("br_valid", {31'b0, if_id_valid}, 32'h0);
    chk("br_instr", if_id_instr, 32'h0);
    tick();
    chk("post_br_addr",  imem_addr, 32'h2C);
    chk("post_br_valid", {31'b0, if_id_valid}, 32'h1);
    chk("post_br_instr", if_id_instr, 32'hA5A5_0028);
    chk("post_br_pc4",   if_id_pc_plus4, 32'h2C);

    // Branch beats a simultaneous jump.
    branch_taken = 1'b1; branch_target = 32'h40;
    jump_en = 1'b1; jump_target = 32'h100;
    tick();
    branch_taken = 1'b0; jump_en = 1'b0;
    chk("bj_addr",  imem_addr, 32'h40);
    chk("bj_valid", {31'b0, if_id_valid}, 32'h0);

    // Jump under stall is ignored until stall drops.
    jump_en = 1'b1; jump_target = 32'h200; stall = 1'b1;
    tick();
    chk("js_addr", imem_addr, 32'h40);
    stall = 1'b0;
    tick();
    jump_en = 1'b0;
    chk("j_addr",  imem_addr, 32'h200);
    chk("j_valid", {31'b0, if_id_valid}, 32'h0);
    tick();
    chk("post_j_addr", imem_addr, 32'h204);
    chk("post_j_pc4",  if_id_pc_plus4, 32'h204);

    // Wrap at the top of the address space.
    jump_en = 1'b1; jump_target = 32'hFFFF_FFFF;
    tick();
    jump_en = 1'b0;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr",  imem_addr, 32'h0);
    chk("wrap_pc4",   if_id_pc_plus4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'h5A5A_FFFC);

    // Asynchronous reset mid-run.
    tick();
    chk("pre_ar_addr", imem_addr, 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("ar_addr",  imem_addr, 32'h0);
    chk("ar_valid", {31'b0, if_id_valid}, 32'h0);
    chk("ar_pc4",   if_id_pc_plus4, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("post_ar_addr", imem_addr, 32'h4);
    chk("post_ar_pc4",  if_id_pc_plus4, 32'h4);

`ifdef FETCH_IRQ_EN
    // User-mode interrupt.
    jump_en = 1'b1; jump_target = 32'h30;
    tick();
    jump_en = 1'b0;
    chk("irq_pre_addr", imem_addr, 32'h30);
    irq = 1'b1;
    tick();
    irq = 1'b0;
    chk("irq_addr",  imem_addr, 32'h8000_0004);
    chk("irq_flag",  {31'b0, if_id_irq}, 32'h1);
    chk("irq_pc4",   if_id_pc_plus4, 32'h30);
    chk("irq_valid", {31'b0, if_id_valid}, 32'h1);
    chk("irq_instr", if_id_instr, 32'h0);
    // Kernel mode ignores irq.
    jump_en = 1'b1; jump_target = 32'h8000_0010;
    tick();
    jump_en = 1'b0;
    irq = 1'b1;
    tick();
    irq = 1'b0;
    chk("kirq_addr", imem_addr, 32'h8000_0014);
    chk("kirq_flag", {31'b0, if_id_irq}, 32'h0);
    chk("kirq_pc4",  if_id_pc_plus4, 32'h8000_0014);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
